aes_round_ctrl: RTL and testbench

Iterative sequencer for the AES encryption round datapath (SubBytes → ShiftRows → MixColumns → AddRoundKey). It accepts one 128-bit plaintext block at a time and performs the initial AddRoundKey itself. It then reuses a single externally instantiated round pipeline NR times, fetching each round key by index and flagging the final round so the wrapper bypasses MixColumns. It sits between the core's input/output handshakes and the round datapath inside the AES core top level.

---
 rtl/aes_pkg.sv | 16 +
 rtl/aes_round_ctrl.sv | 118 +++++++++++
 tb/tb_aes_round_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Constants and FSM encoding shared by the AES core and its round sequencer.
package aes_pkg;

    localparam int NR_AES128  = 10;
    localparam int NR_AES192  = 12;
    localparam int NR_AES256  = 14;
    localparam int AES_KIDX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption sequencer: does the initial AddRoundKey, then launches
// the external round datapath NR times, waiting on its done strobe each round.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int NR     = NR_AES128,
    parameter int KIDX_W = AES_KIDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              key_ready,
    output logic [KIDX_W-1:0] key_idx,
    input  logic [DATA_W-1:0] key_data,
    output logic              rnd_valid,
    output logic [DATA_W-1:0] rnd_data,
    output logic [DATA_W-1:0] rnd_key,
    output logic              rnd_last,
    input  logic              rnd_done,
    input  logic [DATA_W-1:0] rnd_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              err
);

    localparam logic [KIDX_W-1:0] C_LAST = KIDX_W'(NR);
    localparam logic [KIDX_W-1:0] C_ONE  = KIDX_W'(1);

    ctrl_state_t       r_state;
    ctrl_state_t       w_state_nxt;
    logic [DATA_W-1:0] r_st;
    logic [DATA_W-1:0] w_st_nxt;
    logic [KIDX_W-1:0] r_rnd;
    logic [KIDX_W-1:0] w_rnd_nxt;
    logic              r_err;
    logic              w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_st    <= '0;
            r_rnd   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_st    <= w_st_nxt;
            r_rnd   <= w_rnd_nxt;
            // A done strobe outside WAIT is a datapath protocol violation; its result is dropped.
            if (rnd_done && (r_state != ST_WAIT)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign w_last = (r_rnd == C_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_st_nxt    = r_st;
        w_rnd_nxt   = r_rnd;
        in_ready    = 1'b0;
        key_idx     = '0;
        rnd_valid   = 1'b0;
        rnd_key     = '0;
        rnd_last    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = key_ready;
                if (in_valid && key_ready) begin
                    w_st_nxt    = in_data ^ key_data;
                    w_rnd_nxt   = C_ONE;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                key_idx     = r_rnd;
                rnd_valid   = 1'b1;
                rnd_key     = key_data;
                rnd_last    = w_last;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // Round latency is whatever the datapath takes; only rnd_done advances us.
                key_idx = r_rnd;
                if (rnd_done) begin
                    w_st_nxt = rnd_result;
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_rnd_nxt   = r_rnd + C_ONE;
                        w_state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy     = (r_state != ST_IDLE);
    assign rnd_data = r_st;
    assign out_data = r_st;
    assign err      = r_err;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with a behavioural 4-cycle AES round datapath
// and expanded-key store built around the controller.
module tb_aes_round_ctrl;

    localparam int DATA_W = 128;
    localparam int NR     = 10;
    localparam int KIDX_W = 4;
    localparam int L      = 4;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT2      = 128'h3243f6a8885a308d313198a2e0370734;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              key_ready;
    logic [KIDX_W-1:0] key_idx;
    logic [DATA_W-1:0] key_data;
    logic              rnd_valid;
    logic [DATA_W-1:0] rnd_data;
    logic [DATA_W-1:0] rnd_key;
    logic              rnd_last;
    logic              rnd_done;
    logic [DATA_W-1:0] rnd_result;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              err;
    logic              inj_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    aes_round_ctrl #(.DATA_W(DATA_W), .NR(NR), .KIDX_W(KIDX_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .key_ready(key_ready), .key_idx(key_idx), .key_data(key_data),
        .rnd_valid(rnd_valid), .rnd_data(rnd_data), .rnd_key(rnd_key), .rnd_last(rnd_last),
        .rnd_done(rnd_done), .rnd_result(rnd_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .err(err)
    );

    // AES reference pieces: S-box derived from GF(2^8) inverse + affine map.
    logic [7:0]   sbox [256];
    logic [127:0] rk   [NR+1];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] a;
        for (int v = 0; v < 256; v++) begin
            a   = 8'(v);
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, a);
            sbox[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [4*(NR+1)];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 4*(NR+1); i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k <= NR; k++) rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    function automatic logic [127:0] aes_rnd(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
        logic [127:0] t;
        logic [127:0] u;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[127-8*(r+4*c) -: 8] = sbox[s[127-8*(r+4*((c+r)%4)) -: 8]];
        u = t;
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[127-8*(4*c)   -: 8];
                a1 = t[127-8*(4*c+1) -: 8];
                a2 = t[127-8*(4*c+2) -: 8];
                a3 = t[127-8*(4*c+3) -: 8];
                u[127-8*(4*c)   -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                u[127-8*(4*c+1) -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                u[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                u[127-8*(4*c+3) -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        return u ^ k;
    endfunction

    function automatic logic [127:0] ref_enc(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk[0];
        for (int r = 1; r <= NR; r++) s = aes_rnd(s, rk[r], r == NR);
        return s;
    endfunction

    // Key store (combinational read) and L-deep round pipeline sharing the reset.
    assign key_data = (int'(key_idx) <= NR) ? rk[key_idx] : '0;

    logic [L-1:0] pv;
    logic [127:0] pd [L];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
        end else begin
            pv    <= {pv[L-2:0], rnd_valid};
            pd[0] <= aes_rnd(rnd_data, rnd_key, rnd_last);
            for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
        end
    end

    assign rnd_done   = pv[L-1] | inj_done;
    assign rnd_result = pd[L-1];

    // Cycle/event monitor: accept and handshake edges, launch pulses.
    int cyc = 0, acc_cyc = 0, hs_cyc = 0, n_pulse = 0, n_last = 0, last_at = 0;
    int base_pulse = 0, base_last = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (in_valid && in_ready) acc_cyc <= cyc + 1;
            if (out_valid && out_ready) hs_cyc <= cyc + 1;
            if (rnd_valid) begin
                n_pulse <= n_pulse + 1;
                if (rnd_last) begin
                    n_last  <= n_last + 1;
                    last_at <= n_pulse + 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ctl"}, {in_ready, busy, rnd_valid, rnd_last, out_valid, err, key_idx},
            {key_ready, 5'b00000, 4'h0});
        chk({tag, "_data"}, rnd_data | rnd_key | out_data, '0);
    endtask

    // Offer pt and return just after the accept edge; in_valid stays high if hold is set.
    task automatic start_block(input logic [127:0] pt, input logic hold);
        int n;
        n        = 0;
        in_data  = pt;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout", {127'b0, in_ready}, 128'd1);
        base_pulse = n_pulse;
        base_last  = n_last;
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    // Wait for out_valid (stops on a negedge with it high) and check the finished block.
    task automatic wait_out(input string tag, input logic [127:0] exp_ct);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 128'(cyc - acc_cyc + 1), 128'd51);
        chk({tag, "_ct"}, out_data, exp_ct);
        chk({tag, "_pulses"}, 128'(n_pulse - base_pulse), 128'd10);
        chk({tag, "_last"}, {64'(n_last - base_last), 64'(last_at - base_pulse)}, {64'd1, 64'd10});
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_idle"}, {busy, out_valid, in_ready}, {2'b00, key_ready});
    endtask

    initial begin
        int bad;
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        key_ready = 1'b1;
        out_ready = 1'b0;
        inj_done  = 1'b0;
        build_sbox();
        expand_key(FIPS_KEY);
        #3;
        chk_reset_outs("reset_kr1");
        key_ready = 1'b0;
        #1;
        chk_reset_outs("reset_kr0");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // key_ready low blocks acceptance; raising it opens in_ready the same cycle.
        in_data  = FIPS_PT;
        in_valid = 1'b1;
        bad      = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready || rnd_valid || busy) bad++;
        end
        chk("keyrdy_blocked", 128'(bad), 128'd0);
        key_ready = 1'b1;
        #1;
        chk("keyrdy_same_cycle", {127'b0, in_ready}, 128'd1);
        start_block(FIPS_PT, 1'b0);
        chk("issue_first", {busy, rnd_valid, key_idx, rnd_data}, {2'b11, 4'd1, FIPS_PT ^ FIPS_KEY});
        wait_out("fips", FIPS_CT);

        // Output back-pressure: result held, no new block accepted.
        in_data  = PT2;
        in_valid = 1'b1;
        bad      = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (!out_valid || out_data !== FIPS_CT || in_ready || rnd_valid) bad++;
        end
        chk("hold_stable", 128'(bad), 128'd0);
        in_valid = 1'b0;
        handshake("hold");

        // Back-to-back blocks with in_valid and out_ready held high.
        out_ready = 1'b1;
        start_block(FIPS_PT, 1'b1);
        in_data = PT2;
        wait_out("b2b1", FIPS_CT);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_idle", {busy, in_ready}, 2'b01);
        base_pulse = n_pulse;
        base_last  = n_last;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("b2b_gap", 128'(acc_cyc), 128'(hs_cyc + 1));
        wait_out("b2b2", ref_enc(PT2));
        @(posedge clk);
        #1 out_ready = 1'b0;

        // Spurious rnd_done in IDLE: sticky err, FSM unaffected.
        @(negedge clk);
        chk("err_clear", {127'b0, err}, 128'd0);
        inj_done = 1'b1;
        @(posedge clk);
        #1 inj_done = 1'b0;
        @(negedge clk);
        chk("err_set", {busy, err}, 2'b01);
        start_block(FIPS_PT, 1'b0);
        wait_out("err_fips", FIPS_CT);
        chk("err_sticky", {127'b0, err}, 128'd1);
        handshake("err");

        // Reset during round 5 aborts the block.
        start_block(FIPS_PT, 1'b0);
        n = 0;
        @(negedge clk);
        while (!((n_pulse - base_pulse) == 5 && !rnd_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("mid_round5", {busy, key_idx}, {1'b1, 4'd5});
        rst_n = 1'b0;
        #1;
        chk_reset_outs("midreset");
        @(negedge clk);
        chk_reset_outs("midreset_held");
        rst_n = 1'b1;
        @(negedge clk);
        start_block(FIPS_PT, 1'b0);
        wait_out("post_reset", FIPS_CT);
        handshake("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of run, required finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
